// File: rtl/ds2411_pkg.sv
// ============================================================================
// ds2411_pkg : shared types and constants for the DS2411 ID checker
// Rev 1.0
// ============================================================================
`default_nettype none

package ds2411_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GO    = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_RETRY = 3'd4
  } state_t;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_RDERR = 2'b01;
  localparam logic [1:0] FC_CRC   = 2'b10;
  localparam logic [1:0] FC_TMO   = 2'b11;

  // Dallas/Maxim CRC-8 polynomial x^8+x^5+x^4+1, bit-reversed form
  localparam logic [7:0] CRC8_POLY = 8'h8C;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic [7:0] s;
    s = crc >> 1;
    if (crc[0] ^ b) s = s ^ CRC8_POLY;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc8_maxim_serial.sv
// ============================================================================
// crc8_maxim_serial : bit-serial Dallas CRC-8, LSB-first, init 0x00
// Rev 1.0
// ============================================================================
`default_nettype none

module crc8_maxim_serial
  import ds2411_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;
  logic [7:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = crc8_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

`default_nettype wire

// File: rtl/ds2411_id_check.sv
// ============================================================================
// ds2411_id_check : drives the DS2411 reader, validates ROM code, retries
// Rev 1.0
// ============================================================================
`default_nettype none

module ds2411_id_check
  import ds2411_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 3,
  parameter int unsigned GO_HOLD   = 200,
  parameter int unsigned TIMEOUT   = 2_000_000,
  parameter logic [7:0]  FAMILY    = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        rd_go,
  input  logic        rd_done,
  input  logic        rd_error,
  input  logic [63:0] rd_result,
  output logic        busy,
  output logic        id_valid,
  output logic        id_fail,
  output logic [1:0]  fail_code,
  output logic [2:0]  tries,
  output logic [7:0]  family_code,
  output logic [47:0] serial
);

  localparam int unsigned   CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] GO_LAST   = CW'(GO_HOLD - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [2:0]    TRIES_MAX = 3'(MAX_TRIES);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    chk_q, chk_d;
  logic [63:0]   sh_q, sh_d;
  logic          done_prev_q, err_prev_q;
  logic          id_valid_q, id_valid_d;
  logic          id_fail_q, id_fail_d;
  logic [1:0]    fail_code_q, fail_code_d;
  logic [2:0]    tries_q, tries_d;
  logic [7:0]    family_q, family_d;
  logic [47:0]   serial_q, serial_d;

  logic       crc_clr;
  logic       crc_en;
  logic       crc_bit;
  logic [7:0] crc_val;
  logic       done_rise;
  logic       err_rise;

  assign done_rise = rd_done & ~done_prev_q;
  assign err_rise  = rd_error & ~err_prev_q;

  crc8_maxim_serial u_crc (
    .clk    (clk),
    .reset  (reset),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (crc_bit),
    .crc    (crc_val)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    sh_d        = sh_q;
    id_valid_d  = id_valid_q;
    id_fail_d   = id_fail_q;
    fail_code_d = fail_code_q;
    tries_d     = tries_q;
    family_d    = family_q;
    serial_d    = serial_q;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    crc_bit     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d     = ST_GO;
          tries_d     = 3'd1;
          id_valid_d  = 1'b0;
          id_fail_d   = 1'b0;
          fail_code_d = FC_NONE;
        end
      end

      ST_GO: begin
        crc_clr = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == GO_LAST) state_d = ST_WAIT;
      end

      // Bit 0 enters the CRC on the capture edge; the rotate brings the
      // register back to the original code after the 64th bit.
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (err_rise) begin
          fail_code_d = FC_RDERR;
          state_d     = ST_RETRY;
        end else if (done_rise) begin
          sh_d    = {rd_result[0], rd_result[63:1]};
          crc_en  = 1'b1;
          crc_bit = rd_result[0];
          chk_d   = '0;
          state_d = ST_CHECK;
        end else if (cnt_q >= TMO_LAST) begin
          fail_code_d = FC_TMO;
          state_d     = ST_RETRY;
        end
      end

      ST_CHECK: begin
        if (chk_q == 6'd63) begin
          if ((crc_val == 8'h00) && (sh_q[7:0] == FAMILY)) begin
            family_d    = sh_q[7:0];
            serial_d    = sh_q[55:8];
            id_valid_d  = 1'b1;
            fail_code_d = FC_NONE;
            state_d     = ST_IDLE;
          end else begin
            fail_code_d = FC_CRC;
            state_d     = ST_RETRY;
          end
        end else begin
          crc_en  = 1'b1;
          crc_bit = sh_q[0];
          sh_d    = {sh_q[0], sh_q[63:1]};
          chk_d   = chk_q + 6'd1;
        end
      end

      ST_RETRY: begin
        cnt_d = '0;
        if (tries_q >= TRIES_MAX) begin
          id_fail_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          tries_d = tries_q + 3'd1;
          state_d = ST_GO;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      chk_q       <= '0;
      sh_q        <= '0;
      done_prev_q <= 1'b0;
      err_prev_q  <= 1'b0;
      id_valid_q  <= 1'b0;
      id_fail_q   <= 1'b0;
      fail_code_q <= FC_NONE;
      tries_q     <= '0;
      family_q    <= '0;
      serial_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      sh_q        <= sh_d;
      done_prev_q <= rd_done;
      err_prev_q  <= rd_error;
      id_valid_q  <= id_valid_d;
      id_fail_q   <= id_fail_d;
      fail_code_q <= fail_code_d;
      tries_q     <= tries_d;
      family_q    <= family_d;
      serial_q    <= serial_d;
    end
  end

  assign rd_go       = (state_q == ST_GO);
  assign busy        = (state_q != ST_IDLE);
  assign id_valid    = id_valid_q;
  assign id_fail     = id_fail_q;
  assign fail_code   = fail_code_q;
  assign tries       = tries_q;
  assign family_code = family_q;
  assign serial      = serial_q;

endmodule

`default_nettype wire

// File: tb/tb_ds2411_id_check.sv
// ============================================================================
// tb_ds2411_id_check : reader model + outcome model for ds2411_id_check
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ds2411_id_check;

  localparam int unsigned MAX_TRIES = 3;
  localparam int unsigned GO_HOLD   = 20;
  localparam int unsigned TIMEOUT   = 1000;
  localparam logic [7:0]  FAMILY    = 8'h02;
  localparam logic [63:0] GOOD_CODE = 64'hA200_0000_01B8_1C02;
  localparam logic [47:0] GOOD_SER  = 48'h0000_0001_B81C;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rd_go;
  logic        rd_done;
  logic        rd_error;
  logic [63:0] rd_result;
  logic        busy;
  logic        id_valid;
  logic        id_fail;
  logic [1:0]  fail_code;
  logic [2:0]  tries;
  logic [7:0]  family_code;
  logic [47:0] serial;

  ds2411_id_check #(
    .MAX_TRIES (MAX_TRIES),
    .GO_HOLD   (GO_HOLD),
    .TIMEOUT   (TIMEOUT),
    .FAMILY    (FAMILY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .rd_go       (rd_go),
    .rd_done     (rd_done),
    .rd_error    (rd_error),
    .rd_result   (rd_result),
    .busy        (busy),
    .id_valid    (id_valid),
    .id_fail     (id_fail),
    .fail_code   (fail_code),
    .tries       (tries),
    .family_code (family_code),
    .serial      (serial)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference Dallas CRC over the first nbits of v, LSB first
  function automatic logic [7:0] dallas_crc(input logic [63:0] v, input int nbits);
    logic [7:0] c;
    logic       mix;
    c = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mix = c[0] ^ v[i];
      c   = c >> 1;
      if (mix) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  function automatic logic [63:0] make_code(input logic [7:0] fam, input logic [47:0] ser);
    logic [63:0] low;
    low = {8'h00, ser, fam};
    return {dallas_crc(low, 56), low[55:0]};
  endfunction

  // Reader response per attempt: 0 silent, 1 done, 2 error, 3 done+error together
  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] code;
  } resp_t;

  resp_t resp_q[$];
  int    go_pulses  = 0;
  bit    stuck_done = 1'b0;
  int    done_cyc   = 0;

  function automatic resp_t mk(input logic [1:0] kind, input logic [63:0] code);
    resp_t r;
    r.kind = kind;
    r.code = code;
    return r;
  endfunction

  initial begin : reader
    resp_t r;
    rd_done   = 1'b0;
    rd_error  = 1'b0;
    rd_result = '0;
    forever begin
      @(posedge rd_go);
      go_pulses++;
      @(negedge clk);
      if (!stuck_done) rd_done = 1'b0;
      rd_error = 1'b0;
      @(negedge rd_go);
      repeat (3) @(negedge clk);
      if (resp_q.size() > 0) begin
        r = resp_q.pop_front();
        rd_result = r.code;
        if (r.kind == 2'd1 || r.kind == 2'd3) rd_done = 1'b1;
        if (r.kind == 2'd2 || r.kind == 2'd3) rd_error = 1'b1;
        done_cyc = cyc;
      end
    end
  end

  int busy_cycles;

  task automatic acquire(input int limit, input int extra_start_at);
    int n;
    go_pulses = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0;
    n = 0;
    while (busy && n < limit) begin
      busy_cycles++;
      start = (n == extra_start_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("acq_ends", {63'd0, busy}, 64'd0);
  endtask

  logic [47:0] exp_ser;
  logic [7:0]  exp_fam;

  initial begin : main
    int          n;
    int          w;
    logic        exp_ok;
    logic [1:0]  exp_fc;
    int          exp_tries;
    logic [1:0]  kind;
    logic [63:0] code;
    logic [47:0] rser;
    logic [63:0] bad;

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;                       // coincides with reset: must be ignored
    @(negedge clk);
    start = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rd_go", {63'd0, rd_go}, 64'd0);
    check("rst_valid", {63'd0, id_valid}, 64'd0);
    check("rst_fail", {63'd0, id_fail}, 64'd0);
    check("rst_fc", {62'd0, fail_code}, 64'd0);
    check("rst_tries", {61'd0, tries}, 64'd0);
    check("rst_family", {56'd0, family_code}, 64'd0);
    check("rst_serial", {16'd0, serial}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Known-good code, first attempt, with exact timing
    resp_q.delete();
    resp_q.push_back(mk(2'd1, GOOD_CODE));
    go_pulses = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("go_rise", {63'd0, rd_go}, 64'd1);
    check("busy_rise", {63'd0, busy}, 64'd1);
    w = 0;
    while (rd_go && w < 1000) begin
      w++;
      @(negedge clk);
    end
    check("go_width", 64'(w), 64'(GO_HOLD));
    n = 0;
    while (!id_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("valid_latency", 64'(cyc - done_cyc), 64'd65);
    check("k_valid", {63'd0, id_valid}, 64'd1);
    check("k_busy", {63'd0, busy}, 64'd0);
    check("k_family", {56'd0, family_code}, 64'h02);
    check("k_serial", {16'd0, serial}, {16'd0, GOOD_SER});
    check("k_tries", {61'd0, tries}, 64'd1);
    check("k_fc", {62'd0, fail_code}, 64'd0);
    exp_ser = GOOD_SER;
    exp_fam = 8'h02;

    // Corrupted bit 20 on every attempt
    resp_q.delete();
    bad = GOOD_CODE ^ (64'd1 << 20);
    for (int i = 0; i < 3; i++) resp_q.push_back(mk(2'd1, bad));
    acquire(20000, -1);
    check("crc_pulses", 64'(go_pulses), 64'd3);
    check("crc_fail", {63'd0, id_fail}, 64'd1);
    check("crc_valid", {63'd0, id_valid}, 64'd0);
    check("crc_fc", {62'd0, fail_code}, 64'd2);
    check("crc_tries", {61'd0, tries}, 64'd3);
    check("crc_keep_ser", {16'd0, serial}, {16'd0, exp_ser});
    check("crc_keep_fam", {56'd0, family_code}, {56'd0, exp_fam});

    // Error then good, with an ignored start while busy
    resp_q.delete();
    resp_q.push_back(mk(2'd2, GOOD_CODE));
    resp_q.push_back(mk(2'd1, GOOD_CODE));
    acquire(20000, 5);
    check("err_valid", {63'd0, id_valid}, 64'd1);
    check("err_tries", {61'd0, tries}, 64'd2);
    check("err_fc", {62'd0, fail_code}, 64'd0);
    check("err_pulses", 64'(go_pulses), 64'd2);

    // Simultaneous done and error edges: error takes priority
    resp_q.delete();
    resp_q.push_back(mk(2'd3, GOOD_CODE));
    resp_q.push_back(mk(2'd1, GOOD_CODE));
    acquire(20000, -1);
    check("both_tries", {61'd0, tries}, 64'd2);
    check("both_valid", {63'd0, id_valid}, 64'd1);

    // Silent reader: every attempt times out
    resp_q.delete();
    acquire(20000, -1);
    check("tmo_fail", {63'd0, id_fail}, 64'd1);
    check("tmo_fc", {62'd0, fail_code}, 64'd3);
    check("tmo_tries", {61'd0, tries}, 64'd3);
    check("tmo_busy_lo", {63'd0, (busy_cycles >= int'(MAX_TRIES * TIMEOUT))}, 64'd1);
    check("tmo_busy_hi", {63'd0, (busy_cycles <= int'(MAX_TRIES * (TIMEOUT + 2) + 2))}, 64'd1);

    // Done level already high before start and never re-edges
    resp_q.delete();
    @(negedge clk);
    stuck_done = 1'b1;
    rd_result  = GOOD_CODE;
    rd_done    = 1'b1;
    repeat (3) @(negedge clk);
    acquire(20000, -1);
    check("stale_valid", {63'd0, id_valid}, 64'd0);
    check("stale_fail", {63'd0, id_fail}, 64'd1);
    check("stale_fc", {62'd0, fail_code}, 64'd3);
    stuck_done = 1'b0;
    rd_done    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of the CRC walk, then a clean acquisition
    resp_q.delete();
    resp_q.push_back(mk(2'd1, GOOD_CODE));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rd_go && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!rd_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mr_busy", {63'd0, busy}, 64'd0);
    check("mr_rd_go", {63'd0, rd_go}, 64'd0);
    check("mr_valid", {63'd0, id_valid}, 64'd0);
    check("mr_fail", {63'd0, id_fail}, 64'd0);
    check("mr_fc", {62'd0, fail_code}, 64'd0);
    check("mr_tries", {61'd0, tries}, 64'd0);
    check("mr_family", {56'd0, family_code}, 64'd0);
    check("mr_serial", {16'd0, serial}, 64'd0);
    reset = 1'b0;
    exp_ser = '0;
    exp_fam = '0;
    @(negedge clk);
    resp_q.delete();
    resp_q.push_back(mk(2'd1, GOOD_CODE));
    acquire(20000, -1);
    check("post_rst_valid", {63'd0, id_valid}, 64'd1);
    check("post_rst_tries", {61'd0, tries}, 64'd1);
    check("post_rst_serial", {16'd0, serial}, {16'd0, GOOD_SER});
    exp_ser = GOOD_SER;
    exp_fam = 8'h02;

    // Randomized acquisitions against the outcome model
    for (int t = 0; t < 10; t++) begin
      resp_q.delete();
      exp_ok    = 1'b0;
      exp_fc    = 2'b00;
      exp_tries = 0;
      for (int a = 0; a < int'(MAX_TRIES); a++) begin
        rser = {16'($urandom), $urandom};
        code = make_code(FAMILY, rser);
        case ($urandom_range(0, 4))
          0: kind = 2'd1;
          1: begin kind = 2'd1; code = code ^ (64'd1 << $urandom_range(0, 63)); end
          2: begin kind = 2'd1; code = make_code(FAMILY ^ 8'($urandom_range(1, 255)), rser); end
          3: kind = 2'd2;
          default: kind = 2'd3;
        endcase
        resp_q.push_back(mk(kind, code));
        if (!exp_ok) begin
          exp_tries = a + 1;
          if (kind[1]) begin
            exp_fc = 2'b01;
          end else if (dallas_crc(code, 64) == 8'h00 && code[7:0] == FAMILY) begin
            exp_ok  = 1'b1;
            exp_fc  = 2'b00;
            exp_ser = code[55:8];
            exp_fam = code[7:0];
          end else begin
            exp_fc = 2'b10;
          end
        end
      end
      acquire(20000, -1);
      check("rnd_valid", {63'd0, id_valid}, {63'd0, exp_ok});
      check("rnd_fail", {63'd0, id_fail}, {63'd0, ~exp_ok});
      check("rnd_tries", {61'd0, tries}, 64'(exp_tries));
      check("rnd_fc", {62'd0, fail_code}, {62'd0, exp_fc});
      check("rnd_pulses", 64'(go_pulses), 64'(exp_tries));
      check("rnd_serial", {16'd0, serial}, {16'd0, exp_ser});
      check("rnd_family", {56'd0, family_code}, {56'd0, exp_fam});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
